// File: rtl/mdio_controller_pkg.sv
// Shared definitions for the MDIO management controller: FSM encoding,
// opcodes, frame field layout and counter widths.
package mdio_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SHIFT,
    S_RD_ADDR,
    S_RD_TA,
    S_RD_DATA,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int FRAME_W  = 32;
  localparam int DATA_W   = 16;
  localparam int OP_MSB   = 29;
  localparam int OP_LSB   = 28;
  localparam int PHY_MSB  = 27;
  localparam int PHY_LSB  = 23;
  localparam int REG_MSB  = 22;
  localparam int REG_LSB  = 18;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam int DIV_W = 8;
  localparam int CNT_W = 5;
  typedef logic [CNT_W-1:0] cnt_t;

  // Counters hold "events remaining after this one", so 5 bits never wrap.
  localparam cnt_t WR_BITS_LEFT      = 5'd31;
  localparam cnt_t RD_ADDR_BITS_LEFT = 5'd15;
  localparam cnt_t TA_FALLS_LEFT     = 5'd1;
  localparam cnt_t RD_BITS_LEFT      = 5'd15;

  function automatic logic [1:0] frame_op(input logic [FRAME_W-1:0] frame);
    return frame[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/mdio_controller_mdc_clkgen.sv
// Free-running MDC divider; rise/fall strobes are high in the CLK cycle whose
// closing edge toggles MDC, so consumers act on the same edge as MDC moves.
module mdc_clkgen
  import mdio_controller_pkg::*;
#(
  parameter int MDC_HALF = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_mdc,
  output logic o_rise,
  output logic o_fall
);

  logic [DIV_W-1:0] r_div;
  logic             r_mdc;
  logic             w_tick;

  assign w_tick = (r_div == DIV_W'(MDC_HALF - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
      r_mdc <= 1'b0;
    end else if (w_tick) begin
      r_div <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign o_mdc  = r_mdc;
  assign o_rise = w_tick & ~r_mdc;
  assign o_fall = w_tick & r_mdc;

endmodule

// File: rtl/mdio_controller.sv
// MDIO (clause 22 style) frame engine: writes 32-bit frames, reads 16-bit data.
// Drive changes land on MDC falling edges, read samples on MDC rising edges.
module mdio_controller
  import mdio_controller_pkg::*;
#(
  parameter int MDC_HALF = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MDIO_START,
  input  logic [FRAME_W-1:0]  T_DATA,
  input  logic                MDIO_IN,
  output logic                MDC,
  output logic                MDIO_OE,
  output logic                MDIO_OUT,
  output logic [DATA_W-1:0]   RD_DATA,
  output logic                DATA_RDY
);

  logic w_mdc;
  logic w_rise;
  logic w_fall;

  mdc_clkgen #(.MDC_HALF(MDC_HALF)) u_clkgen (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .o_mdc  (w_mdc),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  state_t              r_state;
  logic [FRAME_W-1:0]  r_shift;
  cnt_t                r_cnt;
  logic                r_oe;
  logic                r_out;
  logic [DATA_W-2:0]   r_rx;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rdy;
  logic [1:0]          w_op;

  assign w_op = frame_op(T_DATA);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_oe      <= 1'b0;
      r_out     <= 1'b0;
      r_rx      <= '0;
      r_rd_data <= '0;
      r_rdy     <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MDIO_START && w_op == OP_WRITE) begin
            r_shift <= T_DATA;
            r_cnt   <= '0;
            r_state <= S_WR_SHIFT;
          end else if (MDIO_START && w_op == OP_READ) begin
            r_shift <= T_DATA;
            r_cnt   <= '0;
            r_state <= S_RD_ADDR;
          end
        end
        // OE low here means no bit has been driven yet for this frame.
        S_WR_SHIFT, S_RD_ADDR: begin
          if (w_fall) begin
            if (!r_oe) begin
              r_oe    <= 1'b1;
              r_out   <= r_shift[FRAME_W-1];
              r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
              r_cnt   <= (r_state == S_WR_SHIFT) ? WR_BITS_LEFT : RD_ADDR_BITS_LEFT;
            end else if (r_cnt != '0) begin
              r_out   <= r_shift[FRAME_W-1];
              r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
              r_cnt   <= r_cnt - cnt_t'(1);
            end else begin
              r_oe    <= 1'b0;
              r_out   <= 1'b0;
              r_cnt   <= (r_state == S_WR_SHIFT) ? cnt_t'(0) : TA_FALLS_LEFT;
              r_state <= (r_state == S_WR_SHIFT) ? S_DONE : S_RD_TA;
            end
          end
        end
        S_RD_TA: begin
          if (w_fall) begin
            if (r_cnt == '0) begin
              r_cnt   <= RD_BITS_LEFT;
              r_state <= S_RD_DATA;
            end else begin
              r_cnt <= r_cnt - cnt_t'(1);
            end
          end
        end
        S_RD_DATA: begin
          if (w_rise) begin
            r_rx <= {r_rx[DATA_W-3:0], MDIO_IN};
            if (r_cnt == '0) begin
              r_rd_data <= {r_rx, MDIO_IN};
              r_rdy     <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_cnt <= r_cnt - cnt_t'(1);
            end
          end
        end
        S_DONE: begin
          r_oe    <= 1'b0;
          r_out   <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MDC      = w_mdc;
  assign MDIO_OE  = r_oe;
  assign MDIO_OUT = r_out;
  assign RD_DATA  = r_rd_data;
  assign DATA_RDY = r_rdy;

endmodule

// File: tb/tb_mdio_controller.sv
// Directed bench for mdio_controller with a behavioural PHY register file.
module tb_mdio_controller;
  import mdio_controller_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic        MDC;
  logic        MDIO_OE;
  logic        MDIO_OUT;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;

  mdio_controller #(.MDC_HALF(1)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MDIO_START (MDIO_START),
    .T_DATA     (T_DATA),
    .MDIO_IN    (MDIO_IN),
    .MDC        (MDC),
    .MDIO_OE    (MDIO_OE),
    .MDIO_OUT   (MDIO_OUT),
    .RD_DATA    (RD_DATA),
    .DATA_RDY   (DATA_RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // PHY model, observed on the falling CLK edge away from DUT updates.
  logic [15:0] mem [32][32];
  logic        mem_ready = 1'b0;
  logic        phy_clr = 1'b0;
  logic        p_mdc = 1'b0;
  logic        p_oe = 1'b0;
  logic [63:0] cap;
  logic [31:0] fsh;
  logic [15:0] rd_word;
  logic        rd_act = 1'b0;
  int          ncap = 0, fcnt = 0, k = 0;
  int          oe_rises = 0, rdy_cnt = 0, out_viol = 0;
  time         oe_rise_t = 0;

  initial MDIO_IN = 1'b0;

  always @(negedge CLK) begin
    if (!mem_ready) begin
      for (int a = 0; a < 32; a++)
        for (int r = 0; r < 32; r++) mem[a][r] = 16'h0;
      mem[3][5] = 16'h43AE;
      mem[3][7] = 16'hA5C3;
      mem_ready = 1'b1;
    end
    if (phy_clr) begin
      cap = '0; fsh = '0; ncap = 0; fcnt = 0; k = 0; rd_act = 1'b0;
      oe_rises = 0; rdy_cnt = 0; MDIO_IN = 1'b0;
    end
    if (!MDIO_OE && MDIO_OUT) out_viol++;
    if (DATA_RDY) rdy_cnt++;
    if (MDIO_OE && !p_oe) begin
      if (oe_rises == 0) oe_rise_t = $time;
      oe_rises++;
    end
    if (MDC && !p_mdc) begin
      if (MDIO_OE) begin
        cap = {cap[62:0], MDIO_OUT}; ncap++;
        fsh = {fsh[30:0], MDIO_OUT}; fcnt++;
        if (fcnt == 16 && fsh[OP_MSB-16 -: 2] == OP_READ) begin
          rd_word = mem[fsh[PHY_MSB-16 -: 5]][fsh[REG_MSB-16 -: 5]];
          rd_act = 1'b1;
          k = 0;
        end
        if (fcnt == 32 && fsh[OP_MSB -: 2] == OP_WRITE)
          mem[fsh[PHY_MSB:PHY_LSB]][fsh[REG_MSB:REG_LSB]] = fsh[DATA_MSB:DATA_LSB];
      end
    end else if (!MDC && p_mdc) begin
      if (!MDIO_OE) fcnt = 0;
      // Two turnaround periods, then data MSB first, one bit per falling MDC.
      if (rd_act) begin
        if (k >= 2) MDIO_IN = rd_word[17-k];
        k++;
        if (k >= 18) rd_act = 1'b0;
      end
    end
    p_mdc = MDC;
    p_oe  = MDIO_OE;
  end

  task automatic phy_clear();
    @(posedge CLK); phy_clr = 1'b1;
    @(posedge CLK); phy_clr = 1'b0;
  endtask

  task automatic start_frame(input logic [31:0] frame, output time t0);
    @(negedge CLK);
    T_DATA = frame; MDIO_START = 1'b1; t0 = $time;
    @(negedge CLK);
    MDIO_START = 1'b0; T_DATA = ~frame;
  endtask

  typedef struct {
    logic [31:0] t_data;
    int          exp_bits;
    logic [63:0] exp_cap;
    int          exp_rdy;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [9];
  time  t_start;

  initial begin
    bit seen;
    logic prev_oe;
    vecs[0] = '{32'h569643AE, 32, 64'h569643AE, 0, 16'h0000};
    vecs[1] = '{32'h61940000, 16, 64'h6194,     1, 16'h43AE};
    vecs[2] = '{32'h40000000,  0, 64'h0,        0, 16'h43AE};
    vecs[3] = '{32'h619C0000, 16, 64'h619C,     1, 16'hA5C3};
    vecs[4] = '{32'h519E1234, 32, 64'h519E1234, 0, 16'hA5C3};
    vecs[5] = '{32'h619C0000, 16, 64'h619C,     1, 16'h1234};
    vecs[6] = '{32'h66940000, 16, 64'h6694,     1, 16'h43AE};
    vecs[7] = '{32'h70000000,  0, 64'h0,        0, 16'h43AE};
    vecs[8] = '{32'h00000000,  0, 64'h0,        0, 16'h43AE};

    RESET = 1'b1; MDIO_START = 1'b0; T_DATA = '0;
    repeat (3) @(negedge CLK);
    check("rst_mdc", MDC, 0);
    check("rst_oe", MDIO_OE, 0);
    check("rst_out", MDIO_OUT, 0);
    check("rst_rd_data", RD_DATA, 0);
    check("rst_data_rdy", DATA_RDY, 0);
    RESET = 1'b0;

    for (int i = 0; i < 9; i++) begin
      phy_clear();
      start_frame(vecs[i].t_data, t_start);
      repeat (90) @(negedge CLK);
      check($sformatf("v%0d_nbits", i), ncap, vecs[i].exp_bits);
      check($sformatf("v%0d_bits", i), cap, vecs[i].exp_cap);
      check($sformatf("v%0d_rdy_pulses", i), rdy_cnt, vecs[i].exp_rdy);
      check($sformatf("v%0d_rd_data", i), RD_DATA, vecs[i].exp_rd);
      check($sformatf("v%0d_oe_idle", i), MDIO_OE, 0);
      if (vecs[i].exp_bits > 0)
        check($sformatf("v%0d_first_bit_lat", i),
              (oe_rise_t - t_start >= 20 && oe_rise_t - t_start <= 30), 1);
      else
        check($sformatf("v%0d_no_oe", i), oe_rises, 0);
    end

    // Restart mid-write is ignored: one frame, unchanged.
    phy_clear();
    start_frame(32'h569643AE, t_start);
    repeat (20) @(negedge CLK);
    T_DATA = 32'h61940000; MDIO_START = 1'b1;
    @(negedge CLK);
    MDIO_START = 1'b0;
    repeat (120) @(negedge CLK);
    check("restart_nbits", ncap, 32);
    check("restart_bits", cap, 64'h569643AE);
    check("restart_frames", oe_rises, 1);
    check("restart_rdy", rdy_cnt, 0);

    // Back-to-back write then read, read started in the first IDLE cycle.
    phy_clear();
    start_frame(32'h5696BEEF, t_start);
    seen = 1'b0; prev_oe = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge CLK);
      if (prev_oe && !MDIO_OE) seen = 1'b1;
      prev_oe = MDIO_OE;
    end
    check("b2b_write_done", seen, 1);
    start_frame(32'h66940000, t_start);
    repeat (90) @(negedge CLK);
    check("b2b_nbits", ncap, 48);
    check("b2b_bits", cap, 64'h5696BEEF6694);
    check("b2b_rd_data", RD_DATA, 16'hBEEF);
    check("b2b_rdy", rdy_cnt, 1);

    // Reset in the middle of read data.
    phy_clear();
    start_frame(32'h61940000, t_start);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge CLK);
      if (k >= 11) seen = 1'b1;
    end
    check("mid_rd_reached", seen, 1);
    RESET = 1'b1;
    #1;
    check("mid_rst_mdc", MDC, 0);
    check("mid_rst_oe", MDIO_OE, 0);
    check("mid_rst_out", MDIO_OUT, 0);
    check("mid_rst_rd_data", RD_DATA, 0);
    check("mid_rst_data_rdy", DATA_RDY, 0);
    @(negedge CLK);
    RESET = 1'b0;
    phy_clear();
    repeat (100) @(negedge CLK);
    check("post_rst_no_frame", oe_rises, 0);
    check("post_rst_no_rdy", rdy_cnt, 0);
    check("post_rst_rd_data", RD_DATA, 0);
    check("out_zero_when_oe_low", out_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
